sfft_stream_decoder: RTL and testbench

Converts the NUMINPUTS real and imaginary unary bitstreams leaving the stochastic FFT core back into binary counts. It sits directly downstream of the butterfly network and takes its final-stage oReal/oImg lanes unchanged. Over a fixed window of 2^BITWIDTH enabled cycles it counts the ones on each lane, latches the totals and presents them with a ready/valid handshake and a sticky overrun flag.

---
 rtl/sfft_stream_decoder.sv | 108 ++++++++++
 tb/tb_sfft_stream_decoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sfft_stream_decoder.sv
// Counts ones on each real/imag unary lane over a 2^BITWIDTH-cycle window and
// presents the latched totals through a valid/ready handshake with sticky overrun.
module sfft_stream_decoder #(
  parameter  int BITWIDTH  = 8,
  parameter  int NUMINPUTS = 8,
  localparam int CW        = BITWIDTH + 1
) (
  input  logic                    iClk,
  input  logic                    iRstN,
  input  logic                    iEn,
  input  logic                    iClr,
  input  logic [NUMINPUTS-1:0]    iReal,
  input  logic [NUMINPUTS-1:0]    iImg,
  input  logic                    iReady,
  output logic [NUMINPUTS*CW-1:0] oReal,
  output logic [NUMINPUTS*CW-1:0] oImg,
  output logic                    oValid,
  output logic                    oOvf
);

  localparam logic [BITWIDTH-1:0] WCNT_ONE = {{(BITWIDTH-1){1'b0}}, 1'b1};

  logic [BITWIDTH-1:0]     wcnt_q, wcnt_d;
  logic [CW-1:0]           acc_re_q [NUMINPUTS];
  logic [CW-1:0]           acc_re_d [NUMINPUTS];
  logic [CW-1:0]           acc_im_q [NUMINPUTS];
  logic [CW-1:0]           acc_im_d [NUMINPUTS];
  logic [NUMINPUTS*CW-1:0] out_re_q, out_re_d;
  logic [NUMINPUTS*CW-1:0] out_im_q, out_im_d;
  logic                    valid_q, valid_d;
  logic                    ovf_q, ovf_d;
  logic                    last_cyc;
  logic                    complete;
  logic                    transfer;

  always_comb begin
    wcnt_d   = wcnt_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    out_re_d = out_re_q;
    out_im_d = out_im_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    last_cyc = (wcnt_q == {BITWIDTH{1'b1}});
    complete = iEn && !iClr && last_cyc;
    transfer = valid_q && iReady;

    if (iClr) begin
      wcnt_d  = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      for (int k = 0; k < NUMINPUTS; k++) begin
        acc_re_d[k] = '0;
        acc_im_d[k] = '0;
      end
    end else begin
      if (iEn) begin
        wcnt_d = wcnt_q + WCNT_ONE;
        for (int k = 0; k < NUMINPUTS; k++) begin
          if (last_cyc) begin
            out_re_d[k*CW +: CW] = acc_re_q[k] + CW'(iReal[k]);
            out_im_d[k*CW +: CW] = acc_im_q[k] + CW'(iImg[k]);
            acc_re_d[k]          = '0;
            acc_im_d[k]          = '0;
          end else begin
            acc_re_d[k] = acc_re_q[k] + CW'(iReal[k]);
            acc_im_d[k] = acc_im_q[k] + CW'(iImg[k]);
          end
        end
      end
      // A completion always leaves valid set; overrun only if the old result was never taken.
      if (complete) begin
        valid_d = 1'b1;
        if (valid_q && !iReady) ovf_d = 1'b1;
      end else if (transfer) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      wcnt_q   <= '0;
      out_re_q <= '0;
      out_im_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      for (int k = 0; k < NUMINPUTS; k++) begin
        acc_re_q[k] <= '0;
        acc_im_q[k] <= '0;
      end
    end else begin
      wcnt_q   <= wcnt_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      out_re_q <= out_re_d;
      out_im_q <= out_im_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign oReal  = out_re_q;
  assign oImg   = out_im_q;
  assign oValid = valid_q;
  assign oOvf   = ovf_q;

endmodule

// File: tb/tb_sfft_stream_decoder.sv
// Directed bench for sfft_stream_decoder (BITWIDTH=8, NUMINPUTS=8) with
// hand-computed expected lane counts.
module tb_sfft_stream_decoder;

  localparam int BW = 8;
  localparam int NI = 8;
  localparam int CW = BW + 1;

  logic               iClk = 1'b0;
  logic               iRstN;
  logic               iEn;
  logic               iClr;
  logic [NI-1:0]      iReal;
  logic [NI-1:0]      iImg;
  logic               iReady;
  logic [NI*CW-1:0]   oReal;
  logic [NI*CW-1:0]   oImg;
  logic               oValid;
  logic               oOvf;

  int errors = 0;
  int checks = 0;

  sfft_stream_decoder #(.BITWIDTH(BW), .NUMINPUTS(NI)) dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iEn    (iEn),
    .iClr   (iClr),
    .iReal  (iReal),
    .iImg   (iImg),
    .iReady (iReady),
    .oReal  (oReal),
    .oImg   (oImg),
    .oValid (oValid),
    .oOvf   (oOvf)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [NI*CW-1:0] obs, input logic [NI*CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NI*CW-1:0] pack(input int v0, input int v1, input int v2, input int v3,
                                            input int v4, input int v5, input int v6, input int v7);
    logic [NI*CW-1:0] r;
    r = '0;
    r[0*CW +: CW] = CW'(v0);
    r[1*CW +: CW] = CW'(v1);
    r[2*CW +: CW] = CW'(v2);
    r[3*CW +: CW] = CW'(v3);
    r[4*CW +: CW] = CW'(v4);
    r[5*CW +: CW] = CW'(v5);
    r[6*CW +: CW] = CW'(v6);
    r[7*CW +: CW] = CW'(v7);
    return r;
  endfunction

  initial begin
    logic [NI*CW-1:0] all256;
    logic [NI*CW-1:0] exp_re;
    logic [NI*CW-1:0] exp_im;
    logic [NI-1:0]    pat;
    int               en_idx;
    all256 = pack(256, 256, 256, 256, 256, 256, 256, 256);

    iRstN = 1'b0; iEn = 1'b0; iClr = 1'b0; iReal = '0; iImg = '0; iReady = 1'b0;
    ticks(2);
    chk("rst_real", oReal, '0);
    chk("rst_img", oImg, '0);
    chk("rst_valid", {71'd0, oValid}, 72'd0);
    chk("rst_ovf", {71'd0, oOvf}, 72'd0);

    // Window of all-ones real, zero imag, consumer always ready
    iRstN = 1'b1; iEn = 1'b1; iReal = '1; iImg = '0; iReady = 1'b1;
    ticks(255);
    chk("ones_valid_early", {71'd0, oValid}, 72'd0);
    tick();
    chk("ones_valid", {71'd0, oValid}, 72'd1);
    chk("ones_real", oReal, all256);
    chk("ones_img", oImg, '0);
    tick();
    chk("ones_valid_drop", {71'd0, oValid}, 72'd0);

    // Resync window, then period-(k+2) pattern per lane
    iClr = 1'b1;
    tick();
    iClr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < NI; k++) pat[k] = ((i % (k + 2)) == 0);
      iReal = pat;
      iImg  = ~pat;
      tick();
    end
    exp_re = pack(128, 86, 64, 52, 43, 37, 32, 29);
    exp_im = pack(128, 170, 192, 204, 213, 219, 224, 227);
    chk("period_valid", {71'd0, oValid}, 72'd1);
    chk("period_real", oReal, exp_re);
    chk("period_img", oImg, exp_im);

    // Alternating stream, enable gated for cycles 100..109 with ones driven meanwhile
    iClr = 1'b1;
    tick();
    iClr = 1'b0;
    chk("clr_valid", {71'd0, oValid}, 72'd0);
    en_idx = 0;
    for (int c = 0; c < 266; c++) begin
      if (c >= 100 && c < 110) begin
        iEn = 1'b0; iReal = '1; iImg = '1;
      end else begin
        iEn = 1'b1; iReal = (en_idx % 2 == 0) ? '1 : '0; iImg = '0;
        en_idx++;
      end
      tick();
      if (c == 255) chk("gate_not_yet_valid", {71'd0, oValid}, 72'd0);
      if (c == 264) chk("gate_valid_early", {71'd0, oValid}, 72'd0);
    end
    chk("gate_valid", {71'd0, oValid}, 72'd1);
    chk("gate_real", oReal, pack(128, 128, 128, 128, 128, 128, 128, 128));
    chk("gate_img", oImg, '0);

    // Two windows with no consumer: overrun, then clear retains data
    iClr = 1'b1; iEn = 1'b1;
    tick();
    iClr = 1'b0; iReady = 1'b0;
    iReal = '1; iImg = '0;
    ticks(256);
    chk("ovf1_valid", {71'd0, oValid}, 72'd1);
    chk("ovf1_ovf", {71'd0, oOvf}, 72'd0);
    iReal = 8'h0F; iImg = 8'hF0;
    ticks(256);
    exp_re = pack(256, 256, 256, 256, 0, 0, 0, 0);
    exp_im = pack(0, 0, 0, 0, 256, 256, 256, 256);
    chk("ovf2_valid", {71'd0, oValid}, 72'd1);
    chk("ovf2_ovf", {71'd0, oOvf}, 72'd1);
    chk("ovf2_real", oReal, exp_re);
    chk("ovf2_img", oImg, exp_im);
    iClr = 1'b1;
    tick();
    iClr = 1'b0;
    chk("clr2_valid", {71'd0, oValid}, 72'd0);
    chk("clr2_ovf", {71'd0, oOvf}, 72'd0);
    chk("clr2_real_kept", oReal, exp_re);
    chk("clr2_img_kept", oImg, exp_im);

    // Completion coincides with transfer of a pending result
    iReal = 8'h01; iImg = '0;
    ticks(256);
    chk("pend_valid", {71'd0, oValid}, 72'd1);
    iReal = 8'h02;
    ticks(255);
    iReady = 1'b1;
    tick();
    chk("coin_valid", {71'd0, oValid}, 72'd1);
    chk("coin_ovf", {71'd0, oOvf}, 72'd0);
    chk("coin_real", oReal, pack(0, 256, 0, 0, 0, 0, 0, 0));
    tick();
    chk("coin_drop", {71'd0, oValid}, 72'd0);

    // Reset partway through a window, then a clean full window
    iClr = 1'b1;
    tick();
    iClr = 1'b0;
    iReal = '1; iImg = '1;
    ticks(137);
    iRstN = 1'b0;
    #1;
    chk("arst_real", oReal, '0);
    chk("arst_img", oImg, '0);
    chk("arst_valid", {71'd0, oValid}, 72'd0);
    tick();
    iRstN = 1'b1;
    ticks(255);
    chk("post_rst_early", {71'd0, oValid}, 72'd0);
    tick();
    chk("post_rst_valid", {71'd0, oValid}, 72'd1);
    chk("post_rst_real", oReal, all256);
    chk("post_rst_img", oImg, all256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
